// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
//   Contents: state_t, alu_op_t, ALU control codes, opcodes, mux select codes,
//   and imm_src_for(), which maps an opcode to its immediate format.
package rv_ctrl_pkg;

  // Main FSM states: one per instruction phase.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  // Coarse ALU request from the FSM; FUNCT defers to funct3/funct7.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // ALU control codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Supported opcodes.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Branch funct3 codes.
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Memory address select.
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  // Result select.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU A operand select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  // ALU B operand select.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate formats.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends on the opcode alone, so it is valid in every state.
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    logic [1:0] imm;
    imm = IMM_I;
    case (op)
      OP_LOAD, OP_I: imm = IMM_I;
      OP_STORE:      imm = IMM_S;
      OP_BRANCH:     imm = IMM_B;
      OP_JAL:        imm = IMM_J;
      default:       imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU decoder: turns the FSM's coarse alu_op plus instruction fields into an ALU control code.
// Latency: combinational, zero cycles.
// Backpressure: none; the outputs follow the inputs.
//   Ports: alu_op (from FSM), funct3, funct7b5, op5 (op[5], distinguishes R from I)
//          -> alu_control, illegal (unsupported funct3 while alu_op selects funct decode).
module mc_alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type can subtract; addi with imm[10]=1 also has instr[30]=1.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: begin
            alu_control = ALU_ADD;
            illegal     = 1'b1;
          end
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control unit: Moore main FSM, ALU decode and immediate decode.
// Latency: outputs are combinational from the state and the IR fields; lw 5, sw/R/I/jal 4, branch 3, illegal 2 cycles.
// Backpressure: none; one state per clock, and reset aborts the current instruction immediately.
//   Inputs:  clk, rst_n, op, funct3, funct7b5, zero (ALU flag, only used in BRANCH)
//   Outputs: pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
//            alu_control, imm_src, reg_write, illegal_instr
module mc_control_unit
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal_instr
);

  state_t  state_q, state_d;
  alu_op_t alu_op;

  // Ungated enables; rst_n masks them below so nothing writes during reset.
  logic pc_update;
  logic branch;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic op_illegal;
  logic alu_illegal;
  logic br_illegal;
  logic br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    adr_src       = ADR_PC;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    op_illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight back into the PC while the IR loads.
        ir_write_raw = 1'b1;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALURESULT;
        pc_update    = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm: the branch/jump target, parked in ALUOut for later.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            op_illegal = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = ADR_ALUOUT;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = ADR_ALUOUT;
        mem_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link address OldPC+4.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        result_src    = RES_ALUOUT;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control),
    .illegal     (alu_illegal)
  );

  // beq takes on zero and bne on not-zero; any other funct3 never redirects the PC.
  always_comb begin
    br_taken   = 1'b0;
    br_illegal = 1'b0;
    if (branch) begin
      case (funct3)
        F3_BEQ:  br_taken = zero;
        F3_BNE:  br_taken = ~zero;
        default: br_illegal = 1'b1;
      endcase
    end
  end

  assign imm_src = imm_src_for(op);

  // During reset the state is already FETCH, so only the enables need masking.
  assign pc_write      = rst_n & (pc_update | br_taken);
  assign mem_write     = rst_n & mem_write_raw;
  assign ir_write      = rst_n & ir_write_raw;
  assign reg_write     = rst_n & reg_write_raw;
  assign illegal_instr = rst_n & (op_illegal | alu_illegal | br_illegal);

endmodule
